// File: rtl/aer_pkg.sv
// Shared AER receiver types: address width, address type and receiver FSM states.
package aer_pkg;
    localparam int AER_ADDR_W = 10;

    typedef logic [AER_ADDR_W-1:0] aer_addr_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_SPACE = 2'd1,
        ACK_HI     = 2'd2
    } rx_state_t;
endpackage

// File: rtl/aer_fifo.sv
// Single-clock FIFO whose head is held in an output register, so dout is valid
// on the same cycle that empty deasserts.
module aer_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
    logic [LW-1:0] level_reg;
    logic [W-1:0]  dout_reg;
    logic          pop_ok, push_ok;
    logic [PW-1:0] rd_ptr_inc;

    assign empty      = (level_reg == '0);
    assign full       = (level_reg == LW'(DEPTH));
    assign pop_ok     = pop & ~empty;
    assign push_ok    = push & (~full | pop_ok);
    assign rd_ptr_inc = rd_ptr_reg + PW'(1);

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            level_reg  <= '0;
            dout_reg   <= '0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop_ok)
                rd_ptr_reg <= rd_ptr_inc;
            case ({push_ok, pop_ok})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
            // Next head comes from memory if one remains, else bypasses the incoming word.
            if (pop_ok) begin
                if (level_reg > LW'(1))
                    dout_reg <= mem[rd_ptr_inc];
                else if (push_ok)
                    dout_reg <= din;
            end else if (push_ok && empty) begin
                dout_reg <= din;
            end
        end
    end

    assign dout  = dout_reg;
    assign level = level_reg;
endmodule

// File: rtl/aer_rx.sv
// AER 4-phase receiver: synchronizes REQ, acknowledges into a FIFO, streams events out.
// Optional event counter enabled by defining AER_RX_EVT_CNT_EN.
module aer_rx
    import aer_pkg::*;
#(
    parameter int ADDR_W      = AER_ADDR_W,
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic [ADDR_W-1:0]           AERIN_ADDR,
    input  logic                        AERIN_REQ,
    output logic                        AERIN_ACK,
    output logic [ADDR_W-1:0]           EVT_ADDR,
    output logic                        EVT_VALID,
    input  logic                        EVT_READY,
    output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL,
    output logic                        RX_BUSY
`ifdef AER_RX_EVT_CNT_EN
    ,
    input  logic                        CNT_CLR,
    output logic [15:0]                 EVT_CNT
`endif
);
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   req_s;
    rx_state_t              state_reg, state_next;
    logic                   push, pop;
    logic                   fifo_full, fifo_empty;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            sync_reg <= '0;
        else
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], AERIN_REQ};
    end
    assign req_s = sync_reg[SYNC_STAGES-1];

    assign pop = EVT_VALID & EVT_READY;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        push       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_s)
                    state_next = WAIT_SPACE;
            end
            WAIT_SPACE: begin
                // A request withdrawn before ACK is dropped rather than stalling here.
                if (!req_s) begin
                    state_next = IDLE;
                end else if (!fifo_full || pop) begin
                    push       = 1'b1;
                    state_next = ACK_HI;
                end
            end
            ACK_HI: begin
                if (!req_s)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign AERIN_ACK = (state_reg == ACK_HI);

    aer_fifo #(
        .W     (ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .push  (push),
        .pop   (pop),
        .din   (AERIN_ADDR),
        .dout  (EVT_ADDR),
        .level (FIFO_LEVEL),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign EVT_VALID = ~fifo_empty;
    assign RX_BUSY   = (state_reg != IDLE) | ~fifo_empty;

`ifdef AER_RX_EVT_CNT_EN
    logic [15:0] cnt_reg;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            cnt_reg <= '0;
        else if (CNT_CLR)
            cnt_reg <= push ? 16'd1 : 16'd0;
        else if (push && cnt_reg != 16'hFFFF)
            cnt_reg <= cnt_reg + 16'd1;
    end
    assign EVT_CNT = cnt_reg;
`endif
endmodule

// File: tb/tb_aer_rx.sv
// Self-checking bench for aer_rx: a sender model drives the handshake and a
// queue of expected addresses checks every popped event.
`timescale 1ns/1ps
module tb_aer_rx;
    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [9:0] AERIN_ADDR = '0;
    logic       AERIN_REQ = 1'b0;
    logic       AERIN_ACK;
    logic [9:0] EVT_ADDR;
    logic       EVT_VALID;
    logic       EVT_READY = 1'b0;
    logic [3:0] FIFO_LEVEL;
    logic       RX_BUSY;
`ifdef AER_RX_EVT_CNT_EN
    logic        CNT_CLR = 1'b0;
    logic [15:0] EVT_CNT;
`endif

    int compared = 0;
    int mismatched = 0;
    int pop_cnt = 0;
    logic [9:0] exp_q[$];
    bit rand_ready_en = 0;
    bit bg_done = 0;

    always #5 CLK = ~CLK;

    aer_rx dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .AERIN_ADDR (AERIN_ADDR),
        .AERIN_REQ  (AERIN_REQ),
        .AERIN_ACK  (AERIN_ACK),
        .EVT_ADDR   (EVT_ADDR),
        .EVT_VALID  (EVT_VALID),
        .EVT_READY  (EVT_READY),
        .FIFO_LEVEL (FIFO_LEVEL),
        .RX_BUSY    (RX_BUSY)
`ifdef AER_RX_EVT_CNT_EN
        ,
        .CNT_CLR    (CNT_CLR),
        .EVT_CNT    (EVT_CNT)
`endif
    );

    // Consumer-side reference: each accepted head must match the oldest sent address.
    always @(negedge CLK) begin
        if (RST_N) begin
            compared++;
            if (EVT_VALID !== (FIFO_LEVEL != 4'd0)) begin
                mismatched++;
                $display("FAIL valid_vs_level: valid=%b level=%0d", EVT_VALID, FIFO_LEVEL);
            end
            compared++;
            if (FIFO_LEVEL > 4'd8) begin
                mismatched++;
                $display("FAIL level_range: level=%0d max=8", FIFO_LEVEL);
            end
            if (EVT_VALID && EVT_READY) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_pop: addr=%h expected none", EVT_ADDR);
                end else begin
                    logic [9:0] e;
                    e = exp_q.pop_front();
                    if (EVT_ADDR !== e) begin
                        mismatched++;
                        $display("FAIL pop_addr: got=%h exp=%h", EVT_ADDR, e);
                    end else begin
                        $display("pop addr=%h level=%0d", EVT_ADDR, FIFO_LEVEL);
                    end
                end
                pop_cnt++;
            end
        end
    end

    always @(posedge CLK) begin
        #1;
        if (rand_ready_en)
            EVT_READY = ($urandom_range(0, 9) < 3);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [9:0] a, input int tmo);
        int n;
        AERIN_ADDR = a;
        AERIN_REQ  = 1'b1;
        exp_q.push_back(a);
        n = 0;
        while (AERIN_ACK !== 1'b1 && n < tmo) begin tick(); n++; end
        compared++;
        if (AERIN_ACK !== 1'b1) begin
            mismatched++;
            $display("FAIL ack_rise_timeout: addr=%h ack=%b after %0d cycles", a, AERIN_ACK, n);
        end
        AERIN_REQ = 1'b0;
        n = 0;
        while (AERIN_ACK !== 1'b0 && n < 20) begin tick(); n++; end
        compared++;
        if (AERIN_ACK !== 1'b0) begin
            mismatched++;
            $display("FAIL ack_fall_timeout: addr=%h ack=%b", a, AERIN_ACK);
        end
    endtask

    task automatic drain(input int tmo);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < tmo) begin tick(); n++; end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain_timeout: remaining=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        compared++;
        if ({AERIN_ACK, EVT_VALID, EVT_ADDR, FIFO_LEVEL, RX_BUSY} !== 17'd0) begin
            mismatched++;
            $display("FAIL reset_outputs: ack=%b valid=%b addr=%h level=%0d busy=%b required all 0",
                     AERIN_ACK, EVT_VALID, EVT_ADDR, FIFO_LEVEL, RX_BUSY);
        end
        RST_N = 1'b1;
        repeat (2) tick();
        compared++;
        if ({AERIN_ACK, EVT_VALID, FIFO_LEVEL, RX_BUSY} !== 7'd0) begin
            mismatched++;
            $display("FAIL post_reset_idle: ack=%b valid=%b level=%0d busy=%b", AERIN_ACK, EVT_VALID, FIFO_LEVEL, RX_BUSY);
        end
`ifdef AER_RX_EVT_CNT_EN
        compared++;
        if (EVT_CNT !== 16'd0) begin
            mismatched++;
            $display("FAIL cnt_reset: got=%0d exp=0", EVT_CNT);
        end
`endif
        $display("test_reset done");
    endtask

    task automatic test_single();
        int n;
        EVT_READY  = 1'b1;
        AERIN_ADDR = 10'h2A5;
        AERIN_REQ  = 1'b1;
        exp_q.push_back(10'h2A5);
        n = 0;
        do begin tick(); n++; end while (AERIN_ACK !== 1'b1 && n < 20);
        compared++;
        if (n != 4) begin
            mismatched++;
            $display("FAIL ack_rise_latency: got=%0d exp=4", n);
        end
        compared++;
        if (EVT_VALID !== 1'b1 || EVT_ADDR !== 10'h2A5) begin
            mismatched++;
            $display("FAIL single_head: valid=%b addr=%h exp valid=1 addr=2a5", EVT_VALID, EVT_ADDR);
        end
        tick();
        compared++;
        if (EVT_VALID !== 1'b0) begin
            mismatched++;
            $display("FAIL single_valid_pulse: valid=%b exp=0", EVT_VALID);
        end
        AERIN_REQ = 1'b0;
        n = 0;
        do begin tick(); n++; end while (AERIN_ACK !== 1'b0 && n < 20);
        compared++;
        if (n != 3) begin
            mismatched++;
            $display("FAIL ack_fall_latency: got=%0d exp=3", n);
        end
        $display("test_single rise=4 fall=%0d", n);
    endtask

    task automatic test_fill();
        int n;
        EVT_READY = 1'b0;
        for (int i = 0; i < 8; i++) send(10'(i), 20);
        compared++;
        if (FIFO_LEVEL !== 4'd8) begin
            mismatched++;
            $display("FAIL fill_level: got=%0d exp=8", FIFO_LEVEL);
        end
        bg_done = 0;
        fork
            begin send(10'd8, 200); bg_done = 1; end
        join_none
        repeat (30) tick();
        compared++;
        if (AERIN_ACK !== 1'b0 || FIFO_LEVEL !== 4'd8) begin
            mismatched++;
            $display("FAIL full_backpressure: ack=%b level=%0d exp ack=0 level=8", AERIN_ACK, FIFO_LEVEL);
        end
        EVT_READY = 1'b1;
        n = 0;
        while (AERIN_ACK !== 1'b1 && n < 10) begin tick(); n++; end
        compared++;
        if (n > 2) begin
            mismatched++;
            $display("FAIL ninth_ack_after_pop: cycles=%0d exp<=2", n);
        end
        n = 0;
        while (!bg_done && n < 100) begin tick(); n++; end
        drain(100);
        $display("test_fill done");
    endtask

    task automatic test_wrap();
        EVT_READY = 1'b0;
        for (int i = 0; i < 8; i++) send(10'($urandom), 20);
        rand_ready_en = 1;
        for (int i = 0; i < 12; i++) send(10'($urandom), 400);
        rand_ready_en = 0;
        tick();
        EVT_READY = 1'b1;
        drain(100);
        $display("test_wrap done");
    endtask

    task automatic test_reset_mid();
        EVT_READY = 1'b0;
        send(10'h101, 20);
        send(10'h102, 20);
        AERIN_ADDR = 10'h103;
        AERIN_REQ  = 1'b1;
        exp_q.push_back(10'h103);
        for (int n = 0; n < 20 && AERIN_ACK !== 1'b1; n++) tick();
        compared++;
        if (AERIN_ACK !== 1'b1 || FIFO_LEVEL !== 4'd3) begin
            mismatched++;
            $display("FAIL pre_reset_state: ack=%b level=%0d exp ack=1 level=3", AERIN_ACK, FIFO_LEVEL);
        end
        #2;
        RST_N = 1'b0;
        AERIN_REQ = 1'b0;
        exp_q.delete();
        #1;
        compared++;
        if (AERIN_ACK !== 1'b0 || EVT_VALID !== 1'b0 || FIFO_LEVEL !== 4'd0 || RX_BUSY !== 1'b0) begin
            mismatched++;
            $display("FAIL async_reset: ack=%b valid=%b level=%0d busy=%b exp all 0", AERIN_ACK, EVT_VALID, FIFO_LEVEL, RX_BUSY);
        end
        tick();
        RST_N = 1'b1;
        repeat (2) tick();
        $display("test_reset_mid done");
    endtask

    task automatic test_back_to_back();
        int start_pops;
        int n;
        start_pops = pop_cnt;
        rand_ready_en = 1;
        for (int i = 0; i < 256; i++) send(10'(i), 400);
        rand_ready_en = 0;
        n = 0;
        while (EVT_VALID === 1'b1 && n < 200) begin
            compared++;
            if (RX_BUSY !== 1'b1) begin
                mismatched++;
                $display("FAIL busy_while_buffered: busy=%b exp=1", RX_BUSY);
            end
            if (n == 5) EVT_READY = 1'b1;
            tick();
            n++;
        end
        EVT_READY = 1'b1;
        drain(50);
        compared++;
        if (RX_BUSY !== 1'b0 || pop_cnt - start_pops != 256) begin
            mismatched++;
            $display("FAIL b2b_complete: busy=%b pops=%0d exp busy=0 pops=256", RX_BUSY, pop_cnt - start_pops);
        end
        $display("test_back_to_back pops=%0d", pop_cnt - start_pops);
    endtask

`ifdef AER_RX_EVT_CNT_EN
    task automatic test_evt_cnt();
        EVT_READY = 1'b1;
        CNT_CLR = 1'b1;
        tick();
        CNT_CLR = 1'b0;
        for (int i = 0; i < 5; i++) send(10'(i + 16), 20);
        compared++;
        if (EVT_CNT !== 16'd5) begin
            mismatched++;
            $display("FAIL cnt_five: got=%0d exp=5", EVT_CNT);
        end
        AERIN_ADDR = 10'h3F0;
        AERIN_REQ  = 1'b1;
        exp_q.push_back(10'h3F0);
        repeat (3) tick();
        CNT_CLR = 1'b1;
        tick();
        CNT_CLR = 1'b0;
        compared++;
        if (AERIN_ACK !== 1'b1 || EVT_CNT !== 16'd1) begin
            mismatched++;
            $display("FAIL cnt_clr_push: ack=%b cnt=%0d exp ack=1 cnt=1", AERIN_ACK, EVT_CNT);
        end
        AERIN_REQ = 1'b0;
        for (int n = 0; n < 20 && AERIN_ACK !== 1'b0; n++) tick();
        drain(20);
        $display("test_evt_cnt cnt=%0d", EVT_CNT);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_wrap();
        test_reset_mid();
`ifdef AER_RX_EVT_CNT_EN
        test_evt_cnt();
`endif
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/aer_rx.md
Name: aer_rx

Overview:
- Consumes the 10-bit AER link driven by the input interface: AERIN_ADDR, AERIN_REQ, AERIN_ACK.
- Runs the receiver side of the 4-phase handshake and buffers events in a FIFO.
- Presents events to the SNN core as a valid/ready stream.
- Decouples core processing rate from the encoder/AER sender. Sits directly downstream of the input interface.

Parameters:
- ADDR_W, 10, AER address width; must match sender.
- FIFO_DEPTH, 8, event buffer entries; power of two, at least 2.
- SYNC_STAGES, 2, flip-flop stages on AERIN_REQ; at least 2.

Ports:
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  reset, asynchronous assert, active-low.
- AERIN_ADDR  in  ADDR_W  event address; stable while AERIN_REQ is high.
- AERIN_REQ  in  1  sender request; asynchronous to CLK, synchronized internally.
- AERIN_ACK  out  1  receiver acknowledge, registered.
- EVT_ADDR  out  ADDR_W  head-of-FIFO address.
- EVT_VALID  out  1  FIFO non-empty.
- EVT_READY  in  1  core accepts head; pop when EVT_VALID & EVT_READY.
- FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- RX_BUSY  out  1  FSM not in IDLE, or FIFO non-empty.

Behaviour:
- Reset (RST_N low, async): FSM to IDLE, sync chain cleared, FIFO pointers and level cleared.
  - Outputs: AERIN_ACK=0, EVT_VALID=0, EVT_ADDR=0, FIFO_LEVEL=0, RX_BUSY=0.
  - Deassertion is used directly; the integrator provides a synchronized release.
- req_s = last stage of the SYNC_STAGES chain on AERIN_REQ.
- FSM states:
  - IDLE: req_s=1 -> WAIT_SPACE.
  - WAIT_SPACE: if FIFO not full (level < FIFO_DEPTH), or a pop occurs this cycle:
    - push AERIN_ADDR (sampled this cycle, safe since REQ has been high at least SYNC_STAGES cycles);
    - set AERIN_ACK=1 next edge; go to ACK_HI.
    - Otherwise hold; ACK stays 0 (backpressure to sender).
  - ACK_HI: AERIN_ACK=1; req_s=0 -> AERIN_ACK=0 next edge, go to IDLE.
- Exactly one push per REQ rising phase; a REQ pulse that drops before ACK is not generated by a compliant sender. Behaviour in that case is undefined but must not deadlock: WAIT_SPACE with req_s=0 returns to IDLE without a push.
- Latency: AERIN_REQ rise to AERIN_ACK rise = SYNC_STAGES+2 cycles when FIFO has space. Push to EVT_VALID = 1 cycle (registered FIFO, EVT_ADDR registered from memory).
- FIFO:
  - Pointers of $clog2(FIFO_DEPTH) bits wrap modulo depth.
  - Level is updated +1 on push, -1 on pop, unchanged on simultaneous push and pop.
  - Push when full is allowed only with a simultaneous pop.
  - Pop when empty is ignored.
- EVT_ADDR holds its last value while EVT_VALID=0; it is don't-care for checking.
- Mid-operation reset: ACK drops immediately and buffered events are lost. The sender is reset together with this block.

Optional Feature:
- Macro: AER_RX_EVT_CNT_EN.
- Defined:
  - adds input CNT_CLR (1) and output EVT_CNT (16);
  - EVT_CNT increments on each push, saturates at 16'hFFFF, clears on CNT_CLR;
  - CNT_CLR with a simultaneous push gives result 1;
  - EVT_CNT resets to 0.
- Undefined: ports and counter absent; all other behaviour identical.

Decomposition:
- Package aer_pkg:
  - localparam AER_ADDR_W=10;
  - typedef aer_addr_t (logic [AER_ADDR_W-1:0]);
  - typedef enum rx_state_t {IDLE, WAIT_SPACE, ACK_HI}.
- One sub-module, aer_fifo: synchronous single-clock FIFO with push, pop, din, dout, level, full, empty, parameterized on width and depth.
- The synchronizer is inline.

Test Plan:
- Single event, EVT_READY=1, AERIN_ADDR=10'h2A5:
  - ACK rises SYNC_STAGES+2 cycles after REQ;
  - EVT_VALID pulses 1 cycle with EVT_ADDR=10'h2A5;
  - ACK falls SYNC_STAGES+1 cycles after REQ falls.
- Fill with EVT_READY=0, 9 events (addr 0..8), FIFO_DEPTH=8:
  - 8 ACKs, FIFO_LEVEL=8, 9th REQ unacknowledged;
  - raise EVT_READY: addresses 0..8 pop in order, 9th ACK follows first pop.
- Push/pop same cycle at full: level stays 8, no overflow, order preserved across pointer wrap (20 events, random READY).
- Reset mid-handshake (RST_N low while ACK=1, level=3): ACK=0, EVT_VALID=0, FIFO_LEVEL=0 asynchronously, before next CLK edge.
- Back-to-back sender, 256 events addr=i:
  - every event received exactly once in order;
  - RX_BUSY=0 only after last pop and REQ/ACK low.
- With AER_RX_EVT_CNT_EN: 5 events -> EVT_CNT=5; CNT_CLR coincident with 6th push -> EVT_CNT=1.
